// File: rtl/etapa_escritura.sv
// -----------------------------------------------------------------------------
// etapa_escritura -- writeback stage of the 32-bit pipelined processor.
//
// Consumes the MEM/WB pipeline register outputs, picks the writeback value
// (ALU or memory result), commits it to the 16-entry general register file,
// serves the two decode-stage read ports with optional same-cycle bypass,
// publishes a registered record of the last committed write for EX-stage
// forwarding, and counts committed writes for performance monitoring.
//
// Ports:
//   clk            system clock, all state updates on the rising edge
//   rst            synchronous active-high reset
//   result_alu_in  ALU result from MEM/WB
//   result_mem_in  data-memory result from MEM/WB
//   dir_wb_in      destination register address
//   sel_wb_in      writeback source select (1 = memory, 0 = ALU)
//   reg_wr_in      register write enable
//   dir_a, dir_b   decode-stage read addresses
//   dato_a, dato_b combinational read data (with bypass when BYPASS != 0)
//   fwd_valido     a write committed on the previous rising edge
//   fwd_dir        address of the last committed write
//   fwd_dato       data of the last committed write
//   cuenta_wb      committed writes since reset (wraps silently)
// -----------------------------------------------------------------------------
module etapa_escritura #(
  parameter int ANCHO  = 32,
  parameter int NREG   = 16,
  parameter int BYPASS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ANCHO-1:0] result_alu_in,
  input  logic [ANCHO-1:0] result_mem_in,
  input  logic [3:0]       dir_wb_in,
  input  logic             sel_wb_in,
  input  logic             reg_wr_in,
  input  logic [3:0]       dir_a,
  input  logic [3:0]       dir_b,
  output logic [ANCHO-1:0] dato_a,
  output logic [ANCHO-1:0] dato_b,
  output logic             fwd_valido,
  output logic [3:0]       fwd_dir,
  output logic [ANCHO-1:0] fwd_dato,
  output logic [31:0]      cuenta_wb
);

  localparam bit BYP_EN = (BYPASS != 0);

  // Writeback source mux.
  function automatic logic [ANCHO-1:0] sel_dato_wb(
    input logic             sel_mem,
    input logic [ANCHO-1:0] alu,
    input logic [ANCHO-1:0] mem
  );
    return sel_mem ? mem : alu;
  endfunction

  // Read port with same-cycle bypass of the in-flight write.
  function automatic logic [ANCHO-1:0] leer_puerto(
    input logic [3:0]       dir,
    input logic [ANCHO-1:0] almacenado,
    input logic             vld,
    input logic [3:0]       dir_wb,
    input logic [ANCHO-1:0] dato_wb
  );
    if (BYP_EN && vld && (dir == dir_wb))
      return dato_wb;
    return almacenado;
  endfunction

  // Free-running commit counter; wraps from all-ones to zero with no flag.
  function automatic logic [31:0] inc_cuenta(input logic [31:0] c);
    return c + 32'd1;
  endfunction

  logic [ANCHO-1:0] banco [NREG];

  logic [ANCHO-1:0] dato_wb_p0;
  logic             vld_p0;

  logic             vld_p1;
  logic [3:0]       fwd_dir_p1;
  logic [ANCHO-1:0] fwd_dato_p1;
  logic [31:0]      cuenta_p1;

  // ---- stage p0: writeback value and commit qualifier (combinational) ----
  // A write presented while rst is high is discarded, so it is neither a
  // commit nor a bypass source.
  always_comb begin
    dato_wb_p0 = sel_dato_wb(sel_wb_in, result_alu_in, result_mem_in);
    vld_p0     = reg_wr_in & ~rst;
  end

  always_comb begin
    dato_a = leer_puerto(dir_a, banco[dir_a], vld_p0, dir_wb_in, dato_wb_p0);
    dato_b = leer_puerto(dir_b, banco[dir_b], vld_p0, dir_wb_in, dato_wb_p0);
  end

  // ---- stage p1: register file commit ----
  // The architectural state must read zero after reset, so the array itself
  // is cleared, not just the control path.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++)
        banco[i] <= '0;
    end else if (vld_p0) begin
      banco[dir_wb_in] <= dato_wb_p0;
    end
  end

  // ---- stage p1: forward record and commit counter ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1      <= 1'b0;
      fwd_dir_p1  <= '0;
      fwd_dato_p1 <= '0;
      cuenta_p1   <= '0;
    end else begin
      vld_p1 <= reg_wr_in;
      if (reg_wr_in) begin
        fwd_dir_p1  <= dir_wb_in;
        fwd_dato_p1 <= dato_wb_p0;
        cuenta_p1   <= inc_cuenta(cuenta_p1);
      end
    end
  end

  assign fwd_valido = vld_p1;
  assign fwd_dir    = fwd_dir_p1;
  assign fwd_dato   = fwd_dato_p1;
  assign cuenta_wb  = cuenta_p1;

endmodule

// File: tb/tb_etapa_escritura.sv
module tb_etapa_escritura;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] result_alu_in, result_mem_in;
  logic [3:0]  dir_wb_in, dir_a, dir_b;
  logic        sel_wb_in, reg_wr_in;

  logic [31:0] a1, b1, fd1, cnt1;
  logic [3:0]  fa1;
  logic        fv1;
  logic [31:0] a0, b0, fd0, cnt0;
  logic [3:0]  fa0;
  logic        fv0;

  int n_checks = 0;
  int n_errores = 0;

  // Reference state: architectural view of the register file and outputs.
  logic [31:0] m_reg [16];
  logic [31:0] m_cnt;
  logic        m_fv;
  logic [3:0]  m_fa;
  logic [31:0] m_fd;

  always #5 clk = ~clk;

  etapa_escritura #(.ANCHO(32), .NREG(16), .BYPASS(1)) u_byp (
    .clk(clk), .rst(rst), .result_alu_in(result_alu_in), .result_mem_in(result_mem_in),
    .dir_wb_in(dir_wb_in), .sel_wb_in(sel_wb_in), .reg_wr_in(reg_wr_in),
    .dir_a(dir_a), .dir_b(dir_b), .dato_a(a1), .dato_b(b1),
    .fwd_valido(fv1), .fwd_dir(fa1), .fwd_dato(fd1), .cuenta_wb(cnt1));

  etapa_escritura #(.ANCHO(32), .NREG(16), .BYPASS(0)) u_nbyp (
    .clk(clk), .rst(rst), .result_alu_in(result_alu_in), .result_mem_in(result_mem_in),
    .dir_wb_in(dir_wb_in), .sel_wb_in(sel_wb_in), .reg_wr_in(reg_wr_in),
    .dir_a(dir_a), .dir_b(dir_b), .dato_a(a0), .dato_b(b0),
    .fwd_valido(fv0), .fwd_dir(fa0), .fwd_dato(fd0), .cuenta_wb(cnt0));

  task automatic comprobar(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errores++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_wb();
    return sel_wb_in ? result_mem_in : result_alu_in;
  endfunction

  function automatic logic [31:0] m_leer(input logic [3:0] dir, input bit byp);
    if (byp && !rst && reg_wr_in && dir == dir_wb_in) return m_wb();
    return m_reg[dir];
  endfunction

  // Drive one cycle's inputs on the falling edge and check the read ports.
  task automatic conducir(input logic r, input logic [31:0] alu, input logic [31:0] mem,
                          input logic [3:0] dwb, input logic sel, input logic wr,
                          input logic [3:0] da, input logic [3:0] db);
    @(negedge clk);
    rst = r; result_alu_in = alu; result_mem_in = mem;
    dir_wb_in = dwb; sel_wb_in = sel; reg_wr_in = wr; dir_a = da; dir_b = db;
    #1;
    comprobar("dato_a_byp",  a1, m_leer(dir_a, 1'b1));
    comprobar("dato_b_byp",  b1, m_leer(dir_b, 1'b1));
    comprobar("dato_a_nbyp", a0, m_leer(dir_a, 1'b0));
    comprobar("dato_b_nbyp", b0, m_leer(dir_b, 1'b0));
  endtask

  // Rising edge: advance the reference and check the registered outputs.
  task automatic flanco();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 16; i++) m_reg[i] = '0;
      m_cnt = '0; m_fv = 1'b0; m_fa = '0; m_fd = '0;
    end else begin
      m_fv = reg_wr_in;
      if (reg_wr_in) begin
        m_reg[dir_wb_in] = m_wb();
        m_fa = dir_wb_in;
        m_fd = m_wb();
        m_cnt = m_cnt + 32'd1;
      end
    end
    #1;
    comprobar("fwd_valido", {31'd0, fv1}, {31'd0, m_fv});
    comprobar("fwd_dir",    {28'd0, fa1}, {28'd0, m_fa});
    comprobar("fwd_dato",   fd1, m_fd);
    comprobar("cuenta_wb",  cnt1, m_cnt);
    comprobar("cuenta_wb_nbyp", cnt0, m_cnt);
  endtask

  task automatic ciclo(input logic r, input logic [31:0] alu, input logic [31:0] mem,
                       input logic [3:0] dwb, input logic sel, input logic wr,
                       input logic [3:0] da, input logic [3:0] db);
    conducir(r, alu, mem, dwb, sel, wr, da, db);
    flanco();
  endtask

  initial begin
    rst = 1'b1; result_alu_in = '0; result_mem_in = '0;
    dir_wb_in = '0; sel_wb_in = 1'b0; reg_wr_in = 1'b0; dir_a = '0; dir_b = '0;
    for (int i = 0; i < 16; i++) m_reg[i] = '0;
    m_cnt = '0; m_fv = 1'b0; m_fa = '0; m_fd = '0;

    // Initial reset, then random traffic with occasional resets.
    ciclo(1'b1, 32'h0, 32'h0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0);
    ciclo(1'b1, 32'h0, 32'h0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0);
    comprobar("reset_cuenta", cnt1, 32'd0);
    comprobar("reset_fwd_valido", {31'd0, fv1}, 32'd0);
    for (int k = 0; k < 400; k++) begin
      logic [3:0] dwb;
      dwb = 4'($urandom_range(0, 15));
      ciclo(($urandom_range(0, 39) == 0), $urandom, $urandom, dwb,
            1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 1) == 1) ? dwb : 4'($urandom_range(0, 15)),
            ($urandom_range(0, 1) == 1) ? dwb : 4'($urandom_range(0, 15)));
    end

    // Reset after random writes: every register reads back zero.
    ciclo(1'b0, $urandom, $urandom, 4'd2, 1'b0, 1'b1, 4'd0, 4'd1);
    ciclo(1'b1, $urandom, $urandom, 4'd4, 1'b1, 1'b1, 4'd4, 4'd4);
    ciclo(1'b1, 32'h0, 32'h0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0);
    comprobar("rst2_cuenta", cnt1, 32'd0);
    comprobar("rst2_fwd_valido", {31'd0, fv1}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      conducir(1'b0, 32'h0, 32'h0, 4'd0, 1'b0, 1'b0, 4'(i), 4'(15 - i));
      comprobar("rst2_reg_a", a1, 32'd0);
      comprobar("rst2_reg_b", b1, 32'd0);
      flanco();
    end

    // ALU vs memory select.
    ciclo(1'b0, 32'h11111111, 32'h22222222, 4'd5, 1'b0, 1'b1, 4'd0, 4'd0);
    conducir(1'b0, 32'h0, 32'h0, 4'd0, 1'b0, 1'b0, 4'd5, 4'd5);
    comprobar("sel_alu", a1, 32'h11111111);
    flanco();
    ciclo(1'b0, 32'h11111111, 32'h22222222, 4'd5, 1'b1, 1'b1, 4'd0, 4'd0);
    conducir(1'b0, 32'h0, 32'h0, 4'd0, 1'b0, 1'b0, 4'd5, 4'd5);
    comprobar("sel_mem", a1, 32'h22222222);
    comprobar("sel_cuenta", cnt1, 32'd2);
    comprobar("sel_fwd_dir", {28'd0, fa1}, 32'd5);
    flanco();

    // Bypass: same-cycle read of the address being written.
    ciclo(1'b0, 32'hA, 32'h0, 4'd3, 1'b0, 1'b1, 4'd0, 4'd0);
    conducir(1'b0, 32'hDEADBEEF, 32'h0, 4'd3, 1'b0, 1'b1, 4'd3, 4'd3);
    comprobar("byp_a", a1, 32'hDEADBEEF);
    comprobar("byp_b", b1, 32'hDEADBEEF);
    comprobar("nbyp_a", a0, 32'hA);
    comprobar("nbyp_b", b0, 32'hA);
    flanco();

    // Write disabled: nothing changes, fwd_valido drops.
    ciclo(1'b0, 32'h77, 32'h0, 4'd7, 1'b0, 1'b1, 4'd0, 4'd0);
    ciclo(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd7, 1'b1, 1'b0, 4'd7, 4'd7);
    comprobar("nowr_fwd_valido", {31'd0, fv1}, 32'd0);
    comprobar("nowr_cuenta", cnt1, 32'd5);
    conducir(1'b0, 32'h0, 32'h0, 4'd0, 1'b0, 1'b0, 4'd7, 4'd7);
    comprobar("nowr_reg7", a1, 32'h77);
    flanco();

    // Reset collision: write presented together with rst is discarded.
    ciclo(1'b0, 32'h5555, 32'h0, 4'd9, 1'b0, 1'b1, 4'd0, 4'd0);
    conducir(1'b1, 32'h1234, 32'h0, 4'd9, 1'b0, 1'b1, 4'd9, 4'd9);
    comprobar("rstcol_nobyp", a1, 32'h5555);
    flanco();
    conducir(1'b0, 32'h0, 32'h0, 4'd0, 1'b0, 1'b0, 4'd9, 4'd9);
    comprobar("rstcol_reg9", a1, 32'd0);
    comprobar("rstcol_cuenta", cnt1, 32'd0);
    comprobar("rstcol_fwd_valido", {31'd0, fv1}, 32'd0);
    flanco();

    // Counter wrap: preload the counter, then two commits.
    force u_byp.cuenta_p1 = 32'hFFFFFFFE;
    force u_nbyp.cuenta_p1 = 32'hFFFFFFFE;
    #1;
    release u_byp.cuenta_p1;
    release u_nbyp.cuenta_p1;
    m_cnt = 32'hFFFFFFFE;
    ciclo(1'b0, 32'h1, 32'h0, 4'd1, 1'b0, 1'b1, 4'd0, 4'd0);
    comprobar("wrap_1", cnt1, 32'hFFFFFFFF);
    ciclo(1'b0, 32'h2, 32'h0, 4'd2, 1'b0, 1'b1, 4'd0, 4'd0);
    comprobar("wrap_2", cnt1, 32'h00000000);
    comprobar("wrap_fwd_valido", {31'd0, fv1}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errores);
    $finish;
  end

endmodule
